btn_step_ctrl: RTL and testbench
================================

// Module: btn_step_ctrl
// PURPOSE
//  Controller for the push-button-driven counter datapath. Synchronises and debounces a raw
//  button, sequences single-cycle step pulses (one per press, plus auto-repeat while held),
//  and owns the WIDTH-bit up/down count those steps advance. The counter therefore runs from
//  the system clock instead of being clocked by the button.
// PARAMETERS
//  WIDTH          2    count width; count wraps modulo 2**WIDTH
//  DB_CYCLES      4    consecutive stable cycles required to accept a press or release (>=2)
//  REPEAT_DELAY   8    cycles held after the first step before auto-repeat starts (>=2)
//  REPEAT_PERIOD  4    cycles between auto-repeat steps (>=2)
// PORTS
//  clk      in   1      system clock, all state on posedge
//  rst      in   1      synchronous, active-high reset
//  btn_raw  in   1      raw button, asynchronous and bouncy
//  up       in   1      1 = step increments, 0 = step decrements; sampled at the step edge
//  clr      in   1      synchronous clear of count
//  step     out  1      one-cycle pulse per accepted step
//  count    out  WIDTH  current count
//  wrap     out  1      one-cycle pulse when a step wraps (max->0 up, 0->max down)
//  pressed  out  1      debounced button level (1 in HELD/REPEAT/REL_DB)
// BEHAVIOUR
//  - Reset: step=0, count=0, wrap=0, pressed=0, FSM=IDLE, timer=0, both sync flops=0.
//    Reset mid-press aborts the sequence; a new press needs the full debounce.
//  - Synchroniser: two flops, btn_raw -> s. s lags btn_raw by 2 edges.
//  - timer: clog2(max param) bits, cleared on every state change.
//  - FSM:
//    IDLE:     s=1 -> PRESS_DB.
//    PRESS_DB: s=0 -> IDLE. If s=1 and timer==DB_CYCLES-1 -> HELD and issue step. Else timer++.
//    HELD:     s=0 -> REL_DB. If timer==REPEAT_DELAY-1 -> REPEAT and issue step. Else timer++.
//    REPEAT:   s=0 -> REL_DB. If timer==REPEAT_PERIOD-1 -> issue step, timer=0. Else timer++.
//    REL_DB:   s=1 -> timer=0, stay. If s=0 and timer==DB_CYCLES-1 -> IDLE. Else timer++.
//              No steps are issued in REL_DB.
//  - Step and count timing:
//    step is registered and is high for the cycle after the deciding edge.
//    count and wrap update on that same edge, so count already shows the new value while
//    step=1. Arithmetic is modulo 2**WIDTH: up ? count+1 : count-1.
//  - First step latency: if btn_raw is first sampled high at edge 1 and stays high,
//    step is asserted after edge DB_CYCLES+3.
//    Subsequent steps: +REPEAT_DELAY edges, then every REPEAT_PERIOD edges.
//  - clr has priority over a simultaneous step: count<=0, wrap=0, step still pulses.
//    clr alone: count<=0 with no step.
//  - Simultaneous s=0 and timer expiry in HELD/REPEAT: release wins, no step.
//  - pressed is registered from the next-state value.
// TESTING (WIDTH=2, DB_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=4)
//  1. Assert rst for 3 cycles with btn_raw=1 -> step=0, count=0, wrap=0, pressed=0
//     throughout; first step at edge 7 after rst is released.
//  2. up=1, btn_raw high at edges 1..10, then low -> single step after edge 7; count 0->1;
//     pressed falls after the release debounce; no further steps.
//  3. btn_raw toggling 1,1,0,1,0,0,1,0 (glitches shorter than DB_CYCLES) -> no step,
//     count unchanged, FSM back in IDLE.
//  4. up=1, btn_raw high at edges 1..30 -> steps after edges 7,15,19,23,27,31;
//     count 1,2,3,0,1,2; wrap only with the 4th step.
//  5. count=0, up=0, one clean press -> count=3, wrap=1 for one cycle with step.
//  6. clr=1 on the step edge (count=2) -> count=0, wrap=0, step=1. Also: rst during REPEAT
//     -> all outputs 0 next cycle, no step until edge DB_CYCLES+3 of a new press.

Source files
------------

// File: rtl/btn_step_if.sv
// Button/step bus between the pushbutton controller and whatever drives and observes it.
// The slave side is the controller; the master side supplies the button and step controls.
interface btn_step_if #(
  parameter int unsigned WIDTH = 2
);
  logic             btn_raw;
  logic             up;
  logic             clr;
  logic             step;
  logic [WIDTH-1:0] count;
  logic             wrap;
  logic             pressed;

  modport master (
    output btn_raw, up, clr,
    input  step, count, wrap, pressed
  );

  modport slave (
    input  btn_raw, up, clr,
    output step, count, wrap, pressed
  );
endinterface

// File: rtl/btn_step_ctrl.sv
// Debounced push-button step sequencer with auto-repeat.
// Owns the up/down count, so the count advances on clk rather than on the button.
module btn_step_ctrl #(
  parameter int unsigned WIDTH         = 2,
  parameter int unsigned DB_CYCLES     = 4,
  parameter int unsigned REPEAT_DELAY  = 8,
  parameter int unsigned REPEAT_PERIOD = 4
) (
  input logic      clk,
  input logic      rst,
  btn_step_if.slave bus
);

  localparam int unsigned MAX_AB = (DB_CYCLES > REPEAT_DELAY) ? DB_CYCLES : REPEAT_DELAY;
  localparam int unsigned MAX_P  = (MAX_AB > REPEAT_PERIOD) ? MAX_AB : REPEAT_PERIOD;
  localparam int unsigned TW     = (MAX_P > 1) ? $clog2(MAX_P) : 1;

  localparam logic [TW-1:0]    DB_LAST  = TW'(DB_CYCLES - 1);
  localparam logic [TW-1:0]    RD_LAST  = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0]    RP_LAST  = TW'(REPEAT_PERIOD - 1);
  localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};

  typedef enum logic [2:0] {
    IDLE,
    PRESS_DB,
    HELD,
    REPEAT,
    REL_DB
  } state_t;

  state_t           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             sync1_q, s;
  logic             step_c;
  logic             step_q;
  logic [WIDTH-1:0] count_q;
  logic             wrap_q;
  logic             pressed_q;

  // Two-flop synchroniser for the asynchronous button
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      s       <= 1'b0;
    end else begin
      sync1_q <= bus.btn_raw;
      s       <= sync1_q;
    end
  end

  // State and timer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  // Next-state, timer and step decision; a release always beats a timer expiry
  always_comb begin
    state_d = state_q;
    timer_d = timer_q + TW'(1);
    step_c  = 1'b0;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (s) state_d = PRESS_DB;
      end
      PRESS_DB: begin
        if (!s) begin
          state_d = IDLE;
          timer_d = '0;
        end else if (timer_q == DB_LAST) begin
          state_d = HELD;
          timer_d = '0;
          step_c  = 1'b1;
        end
      end
      HELD: begin
        if (!s) begin
          state_d = REL_DB;
          timer_d = '0;
        end else if (timer_q == RD_LAST) begin
          state_d = REPEAT;
          timer_d = '0;
          step_c  = 1'b1;
        end
      end
      REPEAT: begin
        if (!s) begin
          state_d = REL_DB;
          timer_d = '0;
        end else if (timer_q == RP_LAST) begin
          timer_d = '0;
          step_c  = 1'b1;
        end
      end
      REL_DB: begin
        if (s) begin
          timer_d = '0;
        end else if (timer_q == DB_LAST) begin
          state_d = IDLE;
          timer_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

  // Step pulse, count/wrap update (clr wins over a step) and debounced level
  always_ff @(posedge clk) begin
    if (rst) begin
      step_q    <= 1'b0;
      count_q   <= '0;
      wrap_q    <= 1'b0;
      pressed_q <= 1'b0;
    end else begin
      step_q    <= step_c;
      pressed_q <= (state_d == HELD) || (state_d == REPEAT) || (state_d == REL_DB);
      if (bus.clr) begin
        count_q <= '0;
        wrap_q  <= 1'b0;
      end else if (step_c) begin
        count_q <= bus.up ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
        wrap_q  <= bus.up ? (count_q == CNT_MAX) : (count_q == '0);
      end else begin
        wrap_q  <= 1'b0;
      end
    end
  end

  assign bus.step    = step_q;
  assign bus.count   = count_q;
  assign bus.wrap    = wrap_q;
  assign bus.pressed = pressed_q;

endmodule

// File: tb/tb_btn_step_ctrl.sv
// Directed bench for btn_step_ctrl: expected steps are queued when a press is scheduled
// and popped when the controller pulses step.
module tb_btn_step_ctrl;

  localparam int unsigned WIDTH = 2;

  typedef struct {
    int edge_n;
    int cnt;
    int wr;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   exp_count = 0;
  exp_t q[$];

  btn_step_if #(.WIDTH(WIDTH)) bus ();

  btn_step_ctrl #(
    .WIDTH(WIDTH),
    .DB_CYCLES(4),
    .REPEAT_DELAY(8),
    .REPEAT_PERIOD(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold the button for edges 1..hold; optional clr / rst on a single relative edge.
  task automatic press(input int hold, input bit up_v, input int clr_at, input int rst_at);
    int   base;
    int   rel;
    exp_t x;
    for (int e = 1; e <= hold + 2; e++) begin
      if (e == rst_at) begin
        exp_count = 0;
        continue;
      end
      base = (rst_at > 0 && e > rst_at) ? rst_at : 0;
      rel  = e - base;
      if (!(rel == 7 || rel == 15 || (rel > 15 && (rel - 15) % 4 == 0))) continue;
      if (rel - 2 > hold - base) continue;
      x.edge_n = e;
      if (e == clr_at) begin
        exp_count = 0;
        x.wr      = 0;
      end else begin
        x.wr      = up_v ? int'(exp_count == 3) : int'(exp_count == 0);
        exp_count = up_v ? (exp_count + 1) % 4 : (exp_count + 3) % 4;
      end
      x.cnt = exp_count;
      q.push_back(x);
    end

    for (int e = 1; e <= hold + 12; e++) begin
      bus.btn_raw = (e <= hold);
      bus.up      = up_v;
      bus.clr     = (e == clr_at);
      rst         = (e == rst_at);
      tick();
      if (e == rst_at) begin
        chk("rst_step", 32'(bus.step), 0);
        chk("rst_count", 32'(bus.count), 0);
        chk("rst_wrap", 32'(bus.wrap), 0);
        chk("rst_pressed", 32'(bus.pressed), 0);
      end
      if (bus.step === 1'b1) begin
        if (q.size() == 0) begin
          chk("unexpected_step", e, 0);
        end else begin
          x = q.pop_front();
          chk("step_edge", e, x.edge_n);
          chk("step_count", 32'(bus.count), x.cnt);
          chk("step_wrap", 32'(bus.wrap), x.wr);
          chk("step_pressed", 32'(bus.pressed), 1);
        end
      end else begin
        chk("wrap_no_step", 32'(bus.wrap), 0);
      end
    end
    rst     = 1'b0;
    bus.clr = 1'b0;
    chk("pressed_after_release", 32'(bus.pressed), 0);
    chk("count_after_press", 32'(bus.count), exp_count);
    chk("missing_steps", q.size(), 0);
    q.delete();
  endtask

  task automatic clear_alone();
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    exp_count = 0;
    chk("clr_count", 32'(bus.count), 0);
    chk("clr_no_step", 32'(bus.step), 0);
  endtask

  initial begin
    logic [7:0] glitch;
    rst         = 1'b1;
    bus.btn_raw = 1'b1;
    bus.up      = 1'b1;
    bus.clr     = 1'b0;

    // reset held with the button already down
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset_step", 32'(bus.step), 0);
      chk("reset_count", 32'(bus.count), 0);
      chk("reset_wrap", 32'(bus.wrap), 0);
      chk("reset_pressed", 32'(bus.pressed), 0);
    end

    // first step at edge 7 after reset release, single step for a short hold
    press(10, 1'b1, 0, 0);

    // bounce shorter than the debounce window
    glitch = 8'b0100_1011;
    for (int i = 0; i < 16; i++) begin
      bus.btn_raw = (i < 8) ? glitch[i] : 1'b0;
      tick();
      chk("glitch_no_step", 32'(bus.step), 0);
    end
    chk("glitch_pressed", 32'(bus.pressed), 0);
    chk("glitch_count", 32'(bus.count), exp_count);

    // a clean press after the bounce still needs the full debounce
    press(10, 1'b1, 0, 0);

    clear_alone();
    // long hold: auto-repeat with wrap on the 4th step
    press(30, 1'b1, 0, 0);

    clear_alone();
    // down-count wrap from 0
    press(10, 1'b0, 0, 0);
    press(10, 1'b0, 0, 0);
    // clr on the step edge with count=2
    chk("pre_clr_count", 32'(bus.count), 2);
    press(10, 1'b1, 7, 0);

    // reset during auto-repeat while the button stays down
    press(30, 1'b1, 0, 22);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
